// File: rtl/div_sequencer.sv
// div_sequencer: EX-stage controller that drives the shared iterative divider for DIV/DIVU.
// Latches the operands, pulses the divider start, stalls the pipe until the result returns,
// holds the result while downstream is stalled, and annuls the divider on exception flush.
// Optional feature macro: DIV_ZERO_BYPASS_EN (a divisor of zero completes locally without the divider).

// Fallback ALU-op encodings used when defines.vh is not part of the build.
`ifndef DIV_CONTROL
`define DIV_CONTROL 5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL 5'b11011
`endif

module div_sequencer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       ex_alucontrol,
  input  logic [31:0]      ex_opa,
  input  logic [31:0]      ex_opb,
  input  logic             except_flush,
  input  logic             pipe_hold,
  output logic             div_start,
  output logic             div_signed,
  output logic [31:0]      div_opa,
  output logic [31:0]      div_opb,
  output logic             div_annul,
  input  logic             div_ready,
  input  logic [63:0]      div_result,
  output logic             ex_div_stall,
  output logic             hilo_valid,
  output logic [31:0]      hi_out,
  output logic [31:0]      lo_out,
  output logic [CNT_W-1:0] busy_cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             start_q;
  logic             signed_q;
  logic [31:0]      opa_q, opb_q;
  logic [31:0]      hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic is_div;
  logic accept;
  logic zero_byp;

  assign is_div = (ex_alucontrol == `DIV_CONTROL) || (ex_alucontrol == `DIVU_CONTROL);
  // A flush in the same cycle kills the instruction before it is ever accepted.
  assign accept = (state_q == S_IDLE) && is_div && !except_flush;

`ifdef DIV_ZERO_BYPASS_EN
  // Divide-by-zero never reaches the divider; the result is formed locally.
  assign zero_byp = (ex_opb == 32'd0);
`else
  assign zero_byp = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush outranks div_ready while busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = zero_byp ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (except_flush) begin
          state_d = S_IDLE;
        end else if (div_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (except_flush || !pipe_hold) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: start only in the first busy cycle, annul is same-cycle with the flush.
  always_comb begin
    div_start    = (state_q == S_BUSY) && start_q;
    div_annul    = (state_q == S_BUSY) && except_flush;
    hilo_valid   = (state_q == S_DONE);
    ex_div_stall = accept || (state_q == S_BUSY);
  end

  // Operand/result capture and the saturating busy-cycle counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_q  <= 1'b0;
      signed_q <= 1'b0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      cnt_q    <= '0;
    end else begin
      start_q <= accept && !zero_byp;
      if (accept) begin
        opa_q    <= ex_opa;
        opb_q    <= ex_opb;
        signed_q <= (ex_alucontrol == `DIV_CONTROL);
        cnt_q    <= '0;
        if (zero_byp) begin
          hi_q <= ex_opa;
          lo_q <= 32'hFFFF_FFFF;
        end
      end
      if (state_q == S_BUSY) begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (div_ready && !except_flush) begin
          hi_q <= div_result[63:32];
          lo_q <= div_result[31:0];
        end
      end
    end
  end

  assign div_signed  = signed_q;
  assign div_opa     = opa_q;
  assign div_opb     = opb_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign busy_cycles = cnt_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed bench for div_sequencer; the bench plays the divider.
// Inputs are driven 1 ns after the rising edge and outputs sampled 1 ns later.
// Honours DIV_ZERO_BYPASS_EN when selecting divide-by-zero expectations.

`ifndef DIV_CONTROL
`define DIV_CONTROL 5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL 5'b11011
`endif

module tb_div_sequencer;

  localparam logic [4:0] NOP = 5'b00000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  ex_alucontrol;
  logic [31:0] ex_opa, ex_opb;
  logic        except_flush, pipe_hold;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opa, div_opb;
  logic        div_ready;
  logic [63:0] div_result;
  logic        ex_div_stall, hilo_valid;
  logic [31:0] hi_out, lo_out;
  logic [5:0]  busy_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sequencer #(.CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .ex_alucontrol(ex_alucontrol),
    .ex_opa(ex_opa), .ex_opb(ex_opb), .except_flush(except_flush),
    .pipe_hold(pipe_hold), .div_start(div_start), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul),
    .div_ready(div_ready), .div_result(div_result), .ex_div_stall(ex_div_stall),
    .hilo_valid(hilo_valid), .hi_out(hi_out), .lo_out(lo_out),
    .busy_cycles(busy_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a division in EX during the current cycle (acceptance cycle T).
  task automatic present(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b);
    ex_alucontrol = ctl;
    ex_opa = a;
    ex_opb = b;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ex_alucontrol = NOP; ex_opa = 32'h1234; ex_opb = 32'h5678;
    except_flush = 1'b1; pipe_hold = 1'b1; div_ready = 1'b1; div_result = 64'hDEAD_BEEF_0000_0001;
    repeat (3) tick();
    #1;
    checks++;
    if ({div_start, div_annul, div_signed, hilo_valid, ex_div_stall} !== 5'b0 ||
        div_opa !== 32'd0 || div_opb !== 32'd0 || hi_out !== 32'd0 || lo_out !== 32'd0 || busy_cycles !== 6'd0) begin
      failures++;
      $display("FAIL reset_state: start=%b annul=%b sgn=%b hv=%b stall=%b opa=%h opb=%h hi=%h lo=%h cnt=%0d, required all 0",
               div_start, div_annul, div_signed, hilo_valid, ex_div_stall, div_opa, div_opb, hi_out, lo_out, busy_cycles);
    end
    tick();
    resetn = 1'b1; except_flush = 1'b0; pipe_hold = 1'b0; div_ready = 1'b0;
    tick();
    #1;
    checks++;
    if (hilo_valid !== 1'b0 || ex_div_stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready_ignored: hv=%b stall=%b required 0 0", hilo_valid, ex_div_stall);
    end
  endtask

  // DIV 100/7 with the divider answering 34 cycles after start.
  task automatic test_divide_basic();
    tick();
    present(`DIV_CONTROL, 32'd100, 32'd7);
    #1;
    checks++;
    if (ex_div_stall !== 1'b1) begin
      failures++; $display("FAIL basic_accept_stall: got %b required 1", ex_div_stall);
    end
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k == 35) begin
        div_ready = 1'b1; div_result = {32'd2, 32'd14};
      end
      #1;
      checks++;
      if ({div_start, ex_div_stall, hilo_valid} !== {(k == 1), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL basic_busy k=%0d: start/stall/hv=%b%b%b required %b10", k, div_start, ex_div_stall, hilo_valid, (k == 1));
      end
    end
    tick();
    div_ready = 1'b0;
    #1;
    checks++;
    if ({hilo_valid, ex_div_stall} !== 2'b10 || hi_out !== 32'd2 || lo_out !== 32'd14 || busy_cycles !== 6'd35) begin
      failures++;
      $display("FAIL basic_result: hv=%b stall=%b hi=%0d lo=%0d cnt=%0d required 1 0 2 14 35", hilo_valid, ex_div_stall, hi_out, lo_out, busy_cycles);
    end
    checks++;
    if (div_signed !== 1'b1 || div_opa !== 32'd100 || div_opb !== 32'd7) begin
      failures++;
      $display("FAIL basic_operands: sgn=%b opa=%0d opb=%0d required 1 100 7", div_signed, div_opa, div_opb);
    end
    ex_alucontrol = NOP;
    tick();
    #1;
    checks++;
    if (hilo_valid !== 1'b0) begin
      failures++; $display("FAIL basic_release: hv=%b required 0", hilo_valid);
    end
  endtask

  // DIVU 0xFFFFFFFF/2, downstream holds for 4 cycles after ready.
  task automatic test_hold();
    tick();
    present(`DIVU_CONTROL, 32'hFFFF_FFFF, 32'd2);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin
        div_ready = 1'b1; div_result = {32'd1, 32'h7FFF_FFFF};
      end
    end
    for (int j = 1; j <= 5; j++) begin
      tick();
      div_ready = 1'b0;
      pipe_hold = (j <= 4);
      #1;
      checks++;
      if ({hilo_valid, div_start, ex_div_stall} !== 3'b100 || hi_out !== 32'd1 || lo_out !== 32'h7FFF_FFFF ||
          div_signed !== 1'b0 || div_opa !== 32'hFFFF_FFFF) begin
        failures++;
        $display("FAIL hold_done j=%0d: hv=%b start=%b stall=%b hi=%h lo=%h sgn=%b required 1 0 0 1 7fffffff 0",
                 j, hilo_valid, div_start, ex_div_stall, hi_out, lo_out, div_signed);
      end
    end
    tick();
    pipe_hold = 1'b0; ex_alucontrol = NOP;
    #1;
    checks++;
    if (hilo_valid !== 1'b0) begin
      failures++; $display("FAIL hold_release: hv=%b required 0", hilo_valid);
    end
  endtask

  // Exception flush in the 10th busy cycle; a late div_ready must be ignored.
  task automatic test_flush_busy();
    tick();
    present(`DIV_CONTROL, 32'd50, 32'd5);
    for (int k = 1; k <= 10; k++) begin
      tick();
      except_flush = (k == 10);
      #1;
      checks++;
      if ({div_annul, ex_div_stall} !== {(k == 10), 1'b1}) begin
        failures++; $display("FAIL flush_annul k=%0d: annul/stall=%b%b required %b1", k, div_annul, ex_div_stall, (k == 10));
      end
    end
    tick();
    except_flush = 1'b0; ex_alucontrol = NOP;
    #1;
    checks++;
    if ({ex_div_stall, hilo_valid, div_annul} !== 3'b000) begin
      failures++; $display("FAIL flush_idle: stall/hv/annul=%b%b%b required 000", ex_div_stall, hilo_valid, div_annul);
    end
    tick();
    div_ready = 1'b1; div_result = {32'd0, 32'd10};
    for (int k = 0; k < 3; k++) begin
      tick();
      div_ready = 1'b0;
      #1;
      checks++;
      if ({hilo_valid, ex_div_stall} !== 2'b00) begin
        failures++; $display("FAIL flush_late_ready k=%0d: hv/stall=%b%b required 00", k, hilo_valid, ex_div_stall);
      end
    end
  endtask

  // Flush and div_ready in the same busy cycle: the flush wins.
  task automatic test_flush_ready();
    tick();
    present(`DIV_CONTROL, 32'd81, 32'd9);
    for (int k = 1; k <= 3; k++) begin
      tick();
      except_flush = (k == 3); div_ready = (k == 3); div_result = {32'd0, 32'd9};
      #1;
      checks++;
      if (div_annul !== (k == 3)) begin
        failures++; $display("FAIL flushrdy_annul k=%0d: got %b required %b", k, div_annul, (k == 3));
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      except_flush = 1'b0; div_ready = 1'b0; ex_alucontrol = NOP;
      #1;
      checks++;
      if ({hilo_valid, ex_div_stall} !== 2'b00) begin
        failures++; $display("FAIL flushrdy_no_result k=%0d: hv/stall=%b%b required 00", k, hilo_valid, ex_div_stall);
      end
    end
  endtask

  // Reset mid-division, then a fresh DIV -20/6 against a 1-cycle divider.
  task automatic test_reset_mid_busy();
    tick();
    present(`DIV_CONTROL, 32'd99, 32'd4);
    repeat (3) tick();
    resetn = 1'b0; ex_alucontrol = NOP;
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if ({div_start, div_annul, div_signed, hilo_valid, ex_div_stall} !== 5'b0 ||
        div_opa !== 32'd0 || div_opb !== 32'd0 || hi_out !== 32'd0 || lo_out !== 32'd0 || busy_cycles !== 6'd0) begin
      failures++;
      $display("FAIL midreset_state: start=%b annul=%b sgn=%b hv=%b stall=%b opa=%h hi=%h lo=%h cnt=%0d required all 0",
               div_start, div_annul, div_signed, hilo_valid, ex_div_stall, div_opa, hi_out, lo_out, busy_cycles);
    end
    tick();
    present(`DIV_CONTROL, 32'hFFFF_FFEC, 32'd6);
    tick();
    #1;
    checks++;
    if ({div_start, ex_div_stall} !== 2'b11) begin
      failures++; $display("FAIL fresh_start: start/stall=%b%b required 11", div_start, ex_div_stall);
    end
    tick();
    div_ready = 1'b1; div_result = {32'hFFFF_FFFE, 32'hFFFF_FFFD};
    #1;
    checks++;
    if ({div_start, ex_div_stall, hilo_valid} !== 3'b010) begin
      failures++; $display("FAIL fresh_ready_cycle: start/stall/hv=%b%b%b required 010", div_start, ex_div_stall, hilo_valid);
    end
    tick();
    div_ready = 1'b0;
    #1;
    checks++;
    if ({hilo_valid, ex_div_stall} !== 2'b10 || hi_out !== 32'hFFFF_FFFE || lo_out !== 32'hFFFF_FFFD || busy_cycles !== 6'd2) begin
      failures++;
      $display("FAIL fresh_result: hv=%b stall=%b hi=%h lo=%h cnt=%0d required 1 0 fffffffe fffffffd 2", hilo_valid, ex_div_stall, hi_out, lo_out, busy_cycles);
    end
    ex_alucontrol = NOP;
    tick();
  endtask

  // Second division accepted in the single IDLE cycle after DONE.
  task automatic test_back_to_back();
    tick();
    present(`DIV_CONTROL, 32'd7, 32'd2);
    tick();
    tick();
    div_ready = 1'b1; div_result = {32'd1, 32'd3};
    tick();
    div_ready = 1'b0;
    #1;
    checks++;
    if (hilo_valid !== 1'b1 || hi_out !== 32'd1 || lo_out !== 32'd3) begin
      failures++; $display("FAIL b2b_first: hv=%b hi=%0d lo=%0d required 1 1 3", hilo_valid, hi_out, lo_out);
    end
    tick();
    present(`DIVU_CONTROL, 32'd20, 32'd3);
    #1;
    checks++;
    if ({ex_div_stall, hilo_valid} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept: stall/hv=%b%b required 10", ex_div_stall, hilo_valid);
    end
    tick();
    #1;
    checks++;
    if (div_start !== 1'b1 || div_opa !== 32'd20 || div_opb !== 32'd3 || div_signed !== 1'b0) begin
      failures++; $display("FAIL b2b_start: start=%b opa=%0d opb=%0d sgn=%b required 1 20 3 0", div_start, div_opa, div_opb, div_signed);
    end
    tick();
    div_ready = 1'b1; div_result = {32'd2, 32'd6};
    tick();
    div_ready = 1'b0;
    #1;
    checks++;
    if (hilo_valid !== 1'b1 || hi_out !== 32'd2 || lo_out !== 32'd6) begin
      failures++; $display("FAIL b2b_second: hv=%b hi=%0d lo=%0d required 1 2 6", hilo_valid, hi_out, lo_out);
    end
    ex_alucontrol = NOP;
    tick();
  endtask

  // DIV -8/0: local completion with the bypass, normal divider issue without it.
  task automatic test_div_zero();
    tick();
    present(`DIV_CONTROL, 32'hFFFF_FFF8, 32'd0);
    #1;
    checks++;
    if (ex_div_stall !== 1'b1) begin
      failures++; $display("FAIL zero_accept_stall: got %b required 1", ex_div_stall);
    end
    tick();
    ex_alucontrol = NOP;
    #1;
`ifdef DIV_ZERO_BYPASS_EN
    checks++;
    if ({div_start, hilo_valid, ex_div_stall} !== 3'b010 || hi_out !== 32'hFFFF_FFF8 || lo_out !== 32'hFFFF_FFFF || busy_cycles !== 6'd0) begin
      failures++;
      $display("FAIL zero_bypass: start=%b hv=%b stall=%b hi=%h lo=%h cnt=%0d required 0 1 0 fffffff8 ffffffff 0",
               div_start, hilo_valid, ex_div_stall, hi_out, lo_out, busy_cycles);
    end
    tick();
`else
    checks++;
    if ({div_start, ex_div_stall, hilo_valid} !== 3'b110) begin
      failures++; $display("FAIL zero_start: start/stall/hv=%b%b%b required 110", div_start, ex_div_stall, hilo_valid);
    end
    tick();
    div_ready = 1'b1; div_result = {32'hFFFF_FFF8, 32'hFFFF_FFFF};
    tick();
    div_ready = 1'b0;
    #1;
    checks++;
    if (hilo_valid !== 1'b1 || hi_out !== 32'hFFFF_FFF8 || lo_out !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL zero_divider_result: hv=%b hi=%h lo=%h required 1 fffffff8 ffffffff", hilo_valid, hi_out, lo_out);
    end
    tick();
`endif
    #1;
    checks++;
    if (hilo_valid !== 1'b0) begin
      failures++; $display("FAIL zero_release: hv=%b required 0", hilo_valid);
    end
  endtask

  initial begin
    test_reset();
    test_divide_basic();
    test_hold();
    test_flush_busy();
    test_flush_ready();
    test_reset_mid_busy();
    test_back_to_back();
    test_div_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
